// File: rtl/vbuf_writer1080p.sv
// vbuf_writer1080p: packs a 24bpp raster stream into 128-bit words (16 pixels -> 3 words),
// buffers them in a small word FIFO and writes them to the frame buffer with fixed-length
// Avalon-MM bursts. The layout matches the 1080p scanout reader.
module vbuf_writer1080p #(
    parameter int unsigned BURST    = 16,
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned FDEPTH   = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   bufid,
    input  logic         pix_valid,
    output logic         pix_ready,
    input  logic         pix_sof,
    input  logic [23:0]  pix_rgb,
    output logic [27:0]  vbuf_address,
    output logic [7:0]   vbuf_burstcount,
    output logic         vbuf_write,
    output logic [127:0] vbuf_writedata,
    input  logic         vbuf_waitrequest,
    output logic         frame_done,
    output logic         dropped
);

    localparam int unsigned VMEM_WORDS = H_ACTIVE * V_ACTIVE * 3 / 16;
    localparam int unsigned AW = $clog2(FDEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;
    // Frame buffer window starts at word 0x2000000; buffers are 2^19 words apart.
    localparam logic [27:0] WIN_BASE = 28'h200_0000;
    localparam logic [19:0] VMEM_W   = 20'(VMEM_WORDS);

    typedef enum logic {StIdle, StBurst} state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [18:0]    offset_q, offset_d;
    logic [19:0]    offset_sum;
    logic [1:0]     bufid_q;
    logic           ready_en_q;
    logic           frame_done_q, frame_done_d;
    logic           dropped_q, dropped_d;

    logic [127:0]   acc_q, acc_d;
    logic [3:0]     bc_q, bc_d;
    logic [127:0]   word_q, word_d;
    logic           push_q, push_d;

    logic [127:0]   fifo_mem [FDEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [127:0]   head;

    logic           xfer, sof_accept, sof_block, beat_ok;
    logic [127:0]   acc_base;
    logic [3:0]     bc_base;
    logic [4:0]     pos0, pos1, pos2, end_pos;
    logic [255:0]   ext;

    // Handshake and packer next state: bytes land MSB-first, overflow bytes carry over.
    always_comb begin
        sof_block  = pix_valid && pix_sof &&
                     ((count_q != '0) || (state_q == StBurst) || push_q);
        pix_ready  = ready_en_q && !rst && ((count_q + CW'(push_q)) < CW'(FDEPTH)) &&
                     !sof_block;
        xfer       = pix_valid && pix_ready;
        sof_accept = xfer && pix_sof;
        acc_base   = sof_accept ? '0 : acc_q;
        bc_base    = sof_accept ? '0 : bc_q;
        pos0       = {1'b0, bc_base};
        pos1       = pos0 + 5'd1;
        pos2       = pos0 + 5'd2;
        end_pos    = pos0 + 5'd3;
        // Upper 128 bits are the current word, lower 128 bits catch the carry bytes.
        ext        = {acc_base, 128'b0};
        ext[{~pos0, 3'b000} +: 8] = pix_rgb[23:16];
        ext[{~pos1, 3'b000} +: 8] = pix_rgb[15:8];
        ext[{~pos2, 3'b000} +: 8] = pix_rgb[7:0];

        acc_d     = acc_q;
        bc_d      = bc_q;
        word_d    = word_q;
        push_d    = 1'b0;
        dropped_d = 1'b0;
        if (xfer) begin
            bc_d      = end_pos[3:0];
            dropped_d = sof_accept && (bc_q != '0);
            if (end_pos[4]) begin
                word_d = ext[255:128];
                push_d = 1'b1;
                acc_d  = ext[127:0];
            end else begin
                acc_d = ext[255:128];
            end
        end
    end

    // Write FSM next state: burst starts once a full burst is buffered.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        offset_d     = offset_q;
        frame_done_d = 1'b0;
        beat_ok      = (state_q == StBurst) && !vbuf_waitrequest;
        offset_sum   = {1'b0, offset_q} + 20'(BURST);
        case (state_q)
            StIdle: begin
                if (count_q >= CW'(BURST)) begin
                    state_d = StBurst;
                    beat_d  = '0;
                end
            end
            StBurst: begin
                if (!vbuf_waitrequest) begin
                    if (beat_q == BW'(BURST - 1)) begin
                        state_d = StIdle;
                        beat_d  = '0;
                        if (offset_sum == VMEM_W) begin
                            offset_d     = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            offset_d = offset_sum[18:0];
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (sof_accept) begin
            offset_d = '0;
        end
    end

    // State registers with synchronous reset; a reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            offset_q     <= '0;
            bufid_q      <= '0;
            ready_en_q   <= 1'b0;
            frame_done_q <= 1'b0;
            dropped_q    <= 1'b0;
            acc_q        <= '0;
            bc_q         <= '0;
            word_q       <= '0;
            push_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            offset_q     <= offset_d;
            ready_en_q   <= 1'b1;
            frame_done_q <= frame_done_d;
            dropped_q    <= dropped_d;
            acc_q        <= acc_d;
            bc_q         <= bc_d;
            word_q       <= word_d;
            push_q       <= push_d;
            if (sof_accept) begin
                bufid_q <= bufid;
            end
            if (push_q) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (beat_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_q) - CW'(beat_ok);
        end
    end

    // Word FIFO storage; pointers carry the valid state, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_q) begin
            fifo_mem[wr_ptr_q] <= word_q;
        end
    end

    assign head            = fifo_mem[rd_ptr_q];
    assign vbuf_write      = (state_q == StBurst);
    assign vbuf_address    = vbuf_write ?
                             ((WIN_BASE | {7'b0, bufid_q, 19'b0}) + {9'b0, offset_q}) : '0;
    assign vbuf_burstcount = vbuf_write ? 8'(BURST) : '0;
    // Bus word order swaps the 64-bit halves of the packed word.
    assign vbuf_writedata  = vbuf_write ? {head[63:0], head[127:64]} : '0;
    assign frame_done      = frame_done_q;
    assign dropped         = dropped_q;

endmodule

// File: tb/tb_vbuf_writer1080p.sv
// Testbench for vbuf_writer1080p at a reduced 32x16 raster (96 words, 6 bursts per frame).
// The stimulus pushes expected bus words into a queue; a monitor pops them on each beat.
module tb_vbuf_writer1080p;

    localparam int unsigned BURST  = 16;
    localparam int unsigned HA     = 32;
    localparam int unsigned VA     = 16;
    localparam int unsigned FDEPTH = 32;
    localparam int unsigned VMEM   = HA * VA * 3 / 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   bufid = 2'd0;
    logic         pix_valid = 1'b0;
    logic         pix_ready;
    logic         pix_sof = 1'b0;
    logic [23:0]  pix_rgb = '0;
    logic [27:0]  vbuf_address;
    logic [7:0]   vbuf_burstcount;
    logic         vbuf_write;
    logic [127:0] vbuf_writedata;
    logic         vbuf_waitrequest = 1'b0;
    logic         frame_done;
    logic         dropped;

    vbuf_writer1080p #(
        .BURST    (BURST),
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .FDEPTH   (FDEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bufid            (bufid),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_sof          (pix_sof),
        .pix_rgb          (pix_rgb),
        .vbuf_address     (vbuf_address),
        .vbuf_burstcount  (vbuf_burstcount),
        .vbuf_write       (vbuf_write),
        .vbuf_writedata   (vbuf_writedata),
        .vbuf_waitrequest (vbuf_waitrequest),
        .frame_done       (frame_done),
        .dropped          (dropped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] data;
        logic [27:0]  addr;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;

    // Reference packer state
    logic [127:0] m_acc = '0;
    int           m_bc = 0;
    int           m_word = 0;
    logic [1:0]   m_buf = 2'd0;
    int           exp_frames = 0;
    int           exp_drops = 0;
    int           got_frames = 0;
    int           got_drops = 0;

    int           beats = 0;
    logic         rand_wait = 1'b0;
    logic         abort = 1'b0;
    logic         sender_done = 1'b0;
    logic         hand_word_en = 1'b0;
    logic [127:0] hand_word = '0;
    logic         hand_addr_en = 1'b0;
    logic [27:0]  hand_addr = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        m_acc = m_acc | (128'(b) << (8 * (15 - m_bc)));
        m_bc++;
        if (m_bc == 16) begin
            e.data = {m_acc[63:0], m_acc[127:64]};
            e.addr = 28'h200_0000 + (28'(m_buf) << 19) + 28'((m_word / 16) * 16);
            exp_q.push_back(e);
            m_acc = '0;
            m_bc  = 0;
            m_word++;
            if (m_word == int'(VMEM)) begin
                m_word = 0;
                exp_frames++;
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc  = '0;
        m_bc   = 0;
        m_word = 0;
        m_buf  = 2'd0;
    endtask

    task automatic send_pixel(input logic [23:0] rgb, input logic sof, input logic [1:0] bid);
        int n;
        n = 0;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_rgb   = rgb;
        pix_sof   = sof;
        bufid     = bid;
        #1;
        while (!pix_ready) begin
            if (abort) begin
                pix_valid = 1'b0;
                pix_sof   = 1'b0;
                return;
            end
            n++;
            if (n > 3000) begin
                checks++;
                errors++;
                $display("FAIL pix_ready_timeout: got 0 expected 1");
                pix_valid = 1'b0;
                pix_sof   = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        if (sof) begin
            if (m_bc != 0) exp_drops++;
            m_acc  = '0;
            m_bc   = 0;
            m_word = 0;
            m_buf  = bid;
        end
        model_byte(rgb[23:16]);
        model_byte(rgb[15:8]);
        model_byte(rgb[7:0]);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    function automatic logic [23:0] pat(input int i);
        return 24'(i * 32'h0001_0203) ^ 24'h5A3C96;
    endfunction

    task automatic send_frame(input int n, input logic with_sof, input logic [1:0] bid);
        for (int i = 0; i < n; i++) begin
            if (abort) return;
            send_pixel((i < 16) ? 24'(i + 1) : pat(i), with_sof && (i == 0), bid);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || vbuf_write) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Random 50% waitrequest when enabled, changed just after each active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            vbuf_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Bus monitor: pops the scoreboard per accepted beat and checks stall stability
    initial begin
        exp_t         e;
        logic         prev_write;
        logic         prev_stall;
        logic [27:0]  prev_addr;
        logic [127:0] prev_data;
        prev_write = 1'b0;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                beats      = 0;
                prev_write = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (frame_done) got_frames++;
                if (dropped) got_drops++;
                if (vbuf_write) begin
                    if (prev_stall) begin
                        check("stall_addr", 128'(vbuf_address), 128'(prev_addr));
                        check("stall_data", vbuf_writedata, prev_data);
                    end
                    if (!vbuf_waitrequest) begin
                        beats++;
                        check("burstcount", 128'(vbuf_burstcount), 128'(BURST));
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat: got %0h expected none", vbuf_writedata);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat_data", vbuf_writedata, e.data);
                            check("beat_addr", 128'(vbuf_address), 128'(e.addr));
                        end
                        if (hand_word_en) begin
                            check("first_word", vbuf_writedata, hand_word);
                            hand_word_en = 1'b0;
                        end
                        if (hand_addr_en) begin
                            check("first_addr", 128'(vbuf_address), 128'(hand_addr));
                            hand_addr_en = 1'b0;
                        end
                    end
                    prev_stall = vbuf_waitrequest;
                    prev_addr  = vbuf_address;
                    prev_data  = vbuf_writedata;
                end else begin
                    if (prev_write) check("beats_per_burst", 128'(beats), 128'(BURST));
                    beats      = 0;
                    prev_stall = 1'b0;
                end
                prev_write = vbuf_write;
            end
        end
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pix_ready", 128'(pix_ready), 128'(0));
        check("rst_write", 128'(vbuf_write), 128'(0));
        check("rst_address", 128'(vbuf_address), 128'(0));
        check("rst_frame_done", 128'(frame_done), 128'(0));
        check("rst_dropped", 128'(dropped), 128'(0));
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("ready_after_rst", 128'(pix_ready), 128'(1));

        // Frame A: bufid 0, no stalls, hand-computed first word and base address
        hand_word    = 128'h0300000400000500_0000010000020000;
        hand_word_en = 1'b1;
        hand_addr    = 28'h200_0000;
        hand_addr_en = 1'b1;
        send_frame(HA * VA, 1'b1, 2'd0);
        wait_drain("frame_a");
        check("frames_a", 128'(got_frames), 128'(1));

        // Frame B: bufid 2 with random waitrequest
        rand_wait    = 1'b1;
        hand_addr    = 28'h210_0000;
        hand_addr_en = 1'b1;
        send_frame(HA * VA, 1'b1, 2'd2);
        wait_drain("frame_b");
        rand_wait = 1'b0;
        check("frames_b", 128'(got_frames), 128'(exp_frames));

        // SOF after 5 pixels: partial word dropped, next burst at offset 0 of buffer 1
        send_frame(5, 1'b1, 2'd1);
        hand_addr    = 28'h208_0000;
        hand_addr_en = 1'b1;
        send_frame(HA * VA, 1'b1, 2'd1);
        wait_drain("sof_drop");
        check("drops", 128'(got_drops), 128'(exp_drops));
        check("frames_c", 128'(got_frames), 128'(exp_frames));

        // Reset in the middle of a burst
        sender_done = 1'b0;
        fork
            begin
                send_frame(256, 1'b1, 2'd3);
                sender_done = 1'b1;
            end
        join_none
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(vbuf_write && beats >= 8) && n < 3000);
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL midburst_timeout: got beats %0d expected 8", beats);
        end
        abort = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_write", 128'(vbuf_write), 128'(0));
        check("rst_mid_ready", 128'(pix_ready), 128'(0));
        check("rst_mid_addr", 128'(vbuf_address), 128'(0));
        n = 0;
        while (!sender_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sender_done) begin
            checks++;
            errors++;
            $display("FAIL sender_abort: got busy expected idle");
        end
        @(negedge clk);
        #2;
        model_reset();
        abort = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        #1;
        check("ready_after_mid_rst", 128'(pix_ready), 128'(1));
        hand_addr    = 28'h200_0000;
        hand_addr_en = 1'b1;
        send_frame(256, 1'b0, 2'd0);
        wait_drain("after_rst");

        check("final_frames", 128'(got_frames), 128'(exp_frames));
        check("final_drops", 128'(got_drops), 128'(exp_drops));
        check("final_queue", 128'(exp_q.size()), 128'(0));
        check("hand_checks_used", 128'({hand_word_en, hand_addr_en}), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
